// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte/column types and GF(2^8) helpers
//   byte_t       : one state byte
//   col_t        : one 32-bit state column, row 0 in the top byte
//   AES_POLY_RED : low byte of the reduction polynomial 0x11B
//   xtime        : multiply by 2 in GF(2^8)
//   gf_mul_const : multiply by a 4-bit constant (2, 3, 9, 0b, 0d, 0e) via xtime/XOR
package aes_pkg;
   typedef logic [7:0] byte_t;
   typedef logic [31:0] col_t;
   localparam byte_t AES_POLY_RED = 8'h1B;
   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_RED : 8'h00);
   endfunction
   // Sums b*2^i for each set bit of k; all MixColumns coefficients fit in 4 bits.
   function automatic byte_t gf_mul_const(input byte_t b, input logic [3:0] k);
      byte_t x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
   endfunction
endpackage

// File: rtl/mix_single_column.sv
// mix_single_column: combinational (Inv)MixColumns on one 32-bit column
//   col_in  : input column a0..a3, a0 in bits [31:24]
//   inv     : 0 = MixColumns, 1 = InvMixColumns
//   col_out : transformed column r0..r3, same layout
module mix_single_column
   import aes_pkg::*;
(
   input  col_t col_in,
   input  logic inv,
   output col_t col_out
);
   byte_t a [4];
   logic [3:0] k [4];
   // Both matrices are circulant: row i uses coefficients k rotated by i.
   assign k[0] = inv ? 4'hE : 4'h2;
   assign k[1] = inv ? 4'hB : 4'h3;
   assign k[2] = inv ? 4'hD : 4'h1;
   assign k[3] = inv ? 4'h9 : 4'h1;
   for (genvar i = 0; i < 4; i++) begin : g_row
      assign a[i] = col_in[31-8*i -: 8];
      assign col_out[31-8*i -: 8] = gf_mul_const(a[i], k[0]) ^ gf_mul_const(a[(i+1)%4], k[1])
                                  ^ gf_mul_const(a[(i+2)%4], k[2]) ^ gf_mul_const(a[(i+3)%4], k[3]);
   end
endmodule

// File: rtl/mix_columns.sv
// mix_columns: registered AES (Inv)MixColumns on a 128-bit state, one-cycle latency
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : qualifies in_state and inv
//   inv       : 0 = MixColumns, 1 = InvMixColumns
//   in_state  : column c in bits [127-32c : 96-32c], row 0 most significant
//   out_valid : one-cycle strobe per accepted input
//   out_state : transformed state, held while in_valid is low
module mix_columns
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic         inv,
   input  logic [127:0] in_state,
   output logic         out_valid,
   output logic [127:0] out_state
);
   logic [127:0] mixed;
   for (genvar c = 0; c < 4; c++) begin : g_col
      mix_single_column u_col (
         .col_in (in_state[127-32*c -: 32]),
         .inv    (inv),
         .col_out(mixed[127-32*c -: 32])
      );
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_state <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) out_state <= mixed;
      end
   end
endmodule

// File: tb/tb_mix_columns.sv
// tb_mix_columns: directed and model-checked bench for mix_columns
module tb_mix_columns;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         inv = 1'b0;
   logic [127:0] in_state = '0;
   logic         out_valid;
   logic [127:0] out_state;
   int tests = 0;
   int fails = 0;

   mix_columns dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .inv      (inv),
      .in_state (in_state),
      .out_valid(out_valid),
      .out_state(out_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         inv;
      logic [127:0] in;
      logic [127:0] exp;
   } vec_t;

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [127:0] model(logic [127:0] s, logic iv);
      logic [7:0] row0 [4];
      logic [127:0] r = '0;
      logic [7:0] acc;
      row0[0] = iv ? 8'h0E : 8'h02;
      row0[1] = iv ? 8'h0B : 8'h03;
      row0[2] = iv ? 8'h0D : 8'h01;
      row0[3] = iv ? 8'h09 : 8'h01;
      for (int c = 0; c < 4; c++)
         for (int o = 0; o < 4; o++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc ^= gmul(row0[(j - o + 4) % 4], s[127-32*c-8*j -: 8]);
            r[127-32*c-8*o -: 8] = acc;
         end
      return r;
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs [11];
   logic [127:0] x, y, last;
   logic [127:0] sq [4];
   logic         iq [4];

   initial begin
      vecs[0]  = '{1'b0, 128'hD4BF5D30E0B452AEB84111F11E2798E5, 128'h046681E5E0CB199A48F8D37A2806264C};
      vecs[1]  = '{1'b1, 128'h046681E5E0CB199A48F8D37A2806264C, 128'hD4BF5D30E0B452AEB84111F11E2798E5};
      vecs[2]  = '{1'b0, {4{32'hDB135345}}, {4{32'h8E4DA1BC}}};
      vecs[3]  = '{1'b0, {4{32'hF20A225C}}, {4{32'h9FDC589D}}};
      vecs[4]  = '{1'b0, {4{32'h01010101}}, {4{32'h01010101}}};
      vecs[5]  = '{1'b0, {4{32'hC6C6C6C6}}, {4{32'hC6C6C6C6}}};
      vecs[6]  = '{1'b0, {4{32'hD4D4D4D5}}, {4{32'hD5D5D7D6}}};
      vecs[7]  = '{1'b0, {4{32'h2D26314C}}, {4{32'h4D7EBDF8}}};
      vecs[8]  = '{1'b1, {32'h8E4DA1BC, 32'h9FDC589D, 32'hD5D5D7D6, 32'h4D7EBDF8},
                         {32'hDB135345, 32'hF20A225C, 32'hD4D4D4D5, 32'h2D26314C}};
      vecs[9]  = '{1'b0, {128{1'b1}}, {128{1'b1}}};
      vecs[10] = '{1'b0, 128'h0, 128'h0};

      tick();
      tick();
      check("reset_valid", {127'h0, out_valid}, 128'h0);
      check("reset_state", out_state, 128'h0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         in_valid = 1'b1;
         inv      = vecs[i].inv;
         in_state = vecs[i].in;
         tick();
         check($sformatf("vec%0d_valid", i), {127'h0, out_valid}, 128'h1);
         check($sformatf("vec%0d_state", i), out_state, vecs[i].exp);
         in_valid = 1'b0;
         tick();
         check($sformatf("vec%0d_idle", i), {127'h0, out_valid}, 128'h0);
      end

      for (int i = 0; i < 4; i++) begin
         sq[i] = {$urandom, $urandom, $urandom, $urandom};
         iq[i] = i[0];
      end
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         inv      = iq[i];
         in_state = sq[i];
         tick();
         check($sformatf("stream%0d_valid", i), {127'h0, out_valid}, 128'h1);
         check($sformatf("stream%0d_state", i), out_state, model(sq[i], iq[i]));
      end
      last     = model(sq[3], iq[3]);
      in_valid = 1'b0;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      inv      = 1'b0;
      tick();
      check("stream_end_valid", {127'h0, out_valid}, 128'h0);
      check("stream_hold", out_state, last);
      tick();
      check("stream_hold2", out_state, last);

      rst      = 1'b1;
      in_valid = 1'b1;
      in_state = vecs[0].in;
      tick();
      check("rst_vs_in_valid", {127'h0, out_valid}, 128'h0);
      check("rst_vs_in_state", out_state, 128'h0);
      rst = 1'b0;
      tick();
      check("after_rst_valid", {127'h0, out_valid}, 128'h1);
      check("after_rst_state", out_state, vecs[0].exp);
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      check("rst_discard_valid", {127'h0, out_valid}, 128'h0);
      check("rst_discard_state", out_state, 128'h0);
      rst = 1'b0;

      for (int i = 0; i < 10000; i++) begin
         x        = {$urandom, $urandom, $urandom, $urandom};
         in_valid = 1'b1;
         inv      = 1'b0;
         in_state = x;
         tick();
         y = out_state;
         check("rt_fwd", y, model(x, 1'b0));
         inv      = 1'b1;
         in_state = y;
         tick();
         check("rt_inv", out_state, x);
      end
      in_valid = 1'b0;
      tick();
      check("final_idle", {127'h0, out_valid}, 128'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
